// File: rtl/sdram_wr_datapath_if.sv
// Write-side bundle: upstream word stream (valid/ready) plus the per-burst WRITE command strobes.
// Latency: none, wires only.
// Backpressure: in_ready flows back from the datapath; SDRAM_WR_MASK_EN adds the in_mask lane.
interface sdram_wr_datapath_if #(
  parameter int DW   = 16,
  parameter int BL_W = 4
) ();
  logic            wr_cmd;
  logic [BL_W-1:0] burst_len;
  logic            wr_abort;
  logic [DW-1:0]   in_data;
`ifdef SDRAM_WR_MASK_EN
  logic [DW/8-1:0] in_mask;
`endif
  logic            in_valid;
  logic            in_ready;

`ifdef SDRAM_WR_MASK_EN
  modport master (output wr_cmd, burst_len, wr_abort, in_data, in_mask, in_valid, input in_ready);
  modport slave  (input wr_cmd, burst_len, wr_abort, in_data, in_mask, in_valid, output in_ready);
`else
  modport master (output wr_cmd, burst_len, wr_abort, in_data, in_valid, input in_ready);
  modport slave  (input wr_cmd, burst_len, wr_abort, in_data, in_valid, output in_ready);
`endif
endinterface

// File: rtl/sdram_wr_datapath.sv
// Buffered SDRAM write datapath: queues upstream words, plays each WRITE burst onto DQ/DQM.
// Latency: beat k of a burst accepted at edge N is driven in cycle N+1+k; no FIFO bypass.
// Backpressure: in_ready = !full; a beat due on an empty FIFO is consumed with DQM all ones.
// Optional feature macro SDRAM_WR_MASK_EN: in_mask is stored per word and driven on DQM.

// Generic single-clock FIFO, registered occupancy, read data shown from the head entry.
// Latency: a pushed word is readable from the next edge.
// Backpressure: caller must not push when full nor pop when empty.
module sdram_wr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy = count + push - pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + AW'(1);
      if (rd_vld) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(wr_vld) - CW'(rd_vld);
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign count  = cnt;
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
endmodule

module sdram_wr_datapath #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int BL_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sdram_wr_datapath_if.slave     wr,
  inout  wire  [DW-1:0]          sdram_data,
  output logic [DW/8-1:0]        sdram_dqm,
  output logic                   busy,
  output logic                   underrun,
  output logic                   cmd_err,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int MW = DW / 8;
`ifdef SDRAM_WR_MASK_EN
  localparam int FW = DW + MW;
`else
  localparam int FW = DW;
`endif

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [FW-1:0] fifo_wdat;
  logic [FW-1:0] fifo_rdat;
  logic [MW-1:0] pop_dqm;

  logic [BL_W-1:0] beats_left;
  logic [BL_W-1:0] beats_left_nxt;
  logic            oe_q;
  logic            oe_nxt;
  logic            load;
  logic            cmd_acc;
  logic            cmd_rej;
  logic [DW-1:0]   data_q;
  logic [MW-1:0]   dqm_q;
  logic            underrun_q;
  logic            cmd_err_q;

  assign push        = wr.in_valid && !full;
  assign wr.in_ready = !full;
  // Only a beat load may pop, and never from an empty FIFO
  assign pop         = load && !empty;

`ifdef SDRAM_WR_MASK_EN
  assign fifo_wdat = {wr.in_mask, wr.in_data};
  assign pop_dqm   = fifo_rdat[FW-1:DW];
`else
  assign fifo_wdat = wr.in_data;
  assign pop_dqm   = '0;
`endif

  sdram_wr_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push),
    .wr_dat (fifo_wdat),
    .rd_vld (pop),
    .rd_dat (fifo_rdat),
    .count  (fifo_level),
    .full   (full),
    .empty  (empty)
  );

  // State register: beat counter, output enable, beat data/DQM and the one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left <= '0;
      oe_q       <= 1'b0;
      data_q     <= '0;
      dqm_q      <= '1;
      underrun_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      beats_left <= beats_left_nxt;
      oe_q       <= oe_nxt;
      underrun_q <= load && empty;
      cmd_err_q  <= cmd_rej;
      if (pop) begin
        data_q <= fifo_rdat[DW-1:0];
        dqm_q  <= pop_dqm;
      end else if (load) begin
        // Underrun beat: hold the last data but mask every byte
        dqm_q <= '1;
      end
    end
  end

  // Next state: abort wins, then command acceptance (also in the final beat), then burst progress
  always_comb begin
    cmd_acc        = wr.wr_cmd && (beats_left <= BL_W'(1)) && !wr.wr_abort;
    cmd_rej        = wr.wr_cmd && !cmd_acc;
    beats_left_nxt = beats_left;
    oe_nxt         = oe_q;
    load           = 1'b0;
    if (wr.wr_abort) begin
      beats_left_nxt = '0;
      oe_nxt         = 1'b0;
    end else if (cmd_acc) begin
      beats_left_nxt = (wr.burst_len == '0) ? BL_W'(1) : wr.burst_len;
      oe_nxt         = 1'b1;
      load           = 1'b1;
    end else if (beats_left > BL_W'(1)) begin
      beats_left_nxt = beats_left - BL_W'(1);
      load           = 1'b1;
    end else begin
      beats_left_nxt = '0;
      oe_nxt         = 1'b0;
    end
  end

  // Outputs: DQM forced to all ones whenever DQ is released, status taken from registers
  always_comb begin
    sdram_dqm = oe_q ? dqm_q : '1;
    busy      = (beats_left > BL_W'(1));
    underrun  = underrun_q;
    cmd_err   = cmd_err_q;
  end

  assign sdram_data = oe_q ? data_q : {DW{1'bz}};
endmodule

// File: tb/tb_sdram_wr_datapath.sv
// Bench for sdram_wr_datapath: directed scenarios plus random traffic against a queue-based model.
// Latency: inputs driven on the falling edge, outputs compared 1 time unit after the rising edge.
// Backpressure: the model decides pushes from its own queue occupancy; a pullup reveals released DQ.
module tb_sdram_wr_datapath;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int BL_W  = 4;
  localparam int MW    = DW / 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DQ_Z = {DW{1'b1}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_wr_datapath_if #(.DW(DW), .BL_W(BL_W)) wr_if ();
  wire [DW-1:0] dq;
  pullup (dq);
  logic [MW-1:0] dqm;
  logic          busy;
  logic          underrun;
  logic          cmd_err;
  logic [LW-1:0] level;

  sdram_wr_datapath #(.DW(DW), .DEPTH(DEPTH), .BL_W(BL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if),
    .sdram_data (dq),
    .sdram_dqm  (dqm),
    .busy       (busy),
    .underrun   (underrun),
    .cmd_err    (cmd_err),
    .fifo_level (level)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } word_t;

  word_t         q[$];
  int            rem;
  logic          m_oe;
  logic [DW-1:0] m_dat;
  logic [MW-1:0] m_dqm;
  logic          m_under;
  logic          m_err;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] mask_now();
`ifdef SDRAM_WR_MASK_EN
    return wr_if.in_mask;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    rem = 0; m_oe = 0; m_dat = '0; m_dqm = '1; m_under = 0; m_err = 0;
  endtask

  task automatic play_beat();
    word_t w;
    m_oe = 1;
    if (q.size() > 0) begin
      w = q.pop_front();
      m_dat = w.d;
      m_dqm = w.m;
    end else begin
      m_dqm   = '1;
      m_under = 1;
    end
  endtask

  // One rising edge of the behavioural model, using the inputs held across that edge
  task automatic model_edge();
    bit    do_push;
    word_t w;
    int    bl;
    do_push = wr_if.in_valid && (q.size() < DEPTH);
    w.d     = wr_if.in_data;
    w.m     = mask_now();
    m_err   = wr_if.wr_cmd && (rem > 1 || wr_if.wr_abort);
    m_under = 0;
    if (wr_if.wr_abort) begin
      rem = 0; m_oe = 0;
    end else if (wr_if.wr_cmd && rem <= 1) begin
      bl  = int'(wr_if.burst_len);
      rem = (bl == 0) ? 1 : bl;
      play_beat();
    end else if (rem > 1) begin
      rem--;
      play_beat();
    end else begin
      rem = 0; m_oe = 0;
    end
    if (do_push) q.push_back(w);
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".dq"},       32'(dq),             32'(m_oe ? m_dat : DQ_Z));
    chk({ctx, ".dqm"},      32'(dqm),            32'(m_oe ? m_dqm : {MW{1'b1}}));
    chk({ctx, ".busy"},     32'(busy),           32'(rem > 1));
    chk({ctx, ".underrun"}, 32'(underrun),       32'(m_under));
    chk({ctx, ".cmd_err"},  32'(cmd_err),        32'(m_err));
    chk({ctx, ".level"},    32'(level),          32'(q.size()));
    chk({ctx, ".in_ready"}, 32'(wr_if.in_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(ctx);
    @(negedge clk);
    wr_if.wr_cmd   = 0;
    wr_if.wr_abort = 0;
    wr_if.in_valid = 0;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [MW-1:0] m);
    wr_if.in_valid = 1;
    wr_if.in_data  = d;
`ifdef SDRAM_WR_MASK_EN
    wr_if.in_mask  = m;
`else
    if (m != '0) $display("note: mask ignored without mask feature");
`endif
    step("push");
  endtask

  task automatic cmd(input int bl);
    wr_if.wr_cmd    = 1;
    wr_if.burst_len = BL_W'(bl);
    step("cmd");
  endtask

  initial begin
    logic [DW-1:0] pat [4];
    int uc;
    int drv;
    pat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wr_if.wr_cmd = 0; wr_if.burst_len = '0; wr_if.wr_abort = 0;
    wr_if.in_data = '0; wr_if.in_valid = 0;
`ifdef SDRAM_WR_MASK_EN
    wr_if.in_mask = '0;
`endif
    rst_n = 0;
    model_reset();
    #1;
    chk("rst.dq",       32'(dq), 32'(DQ_Z));
    chk("rst.dqm",      32'(dqm), 32'h3);
    chk("rst.in_ready", 32'(wr_if.in_ready), 32'h1);
    chk("rst.level",    32'(level), 32'h0);
    chk("rst.busy",     32'(busy), 32'h0);
    chk("rst.underrun", 32'(underrun), 32'h0);
    chk("rst.cmd_err",  32'(cmd_err), 32'h0);
    @(negedge clk);
    rst_n = 1;
    step("idle");

    // Basic 4-beat burst
    for (int i = 0; i < 4; i++) push_word(pat[i], '0);
    cmd(4);
    chk("plan1.beat0", 32'(dq), 32'(pat[0]));
    chk("plan1.dqm0",  32'(dqm), 32'h0);
    for (int i = 1; i < 4; i++) begin
      step("plan1");
      chk("plan1.beat", 32'(dq), 32'(pat[i]));
    end
    step("plan1");
    chk("plan1.z",     32'(dq), 32'(DQ_Z));
    chk("plan1.level", 32'(level), 32'h0);

    // Fill to full, overfill attempt, then drain with a gapless 15+1
    for (int i = 0; i < DEPTH; i++) push_word(DW'(16'h0100 + i), '0);
    chk("full.in_ready", 32'(wr_if.in_ready), 32'h0);
    push_word(16'h0BAD, '0);
    chk("full.level", 32'(level), 32'd16);
    cmd(15);
    repeat (14) step("drain");
    cmd(1);
    step("drain");
    chk("drain.level", 32'(level), 32'h0);

    // Underrun: two words for a 4-beat burst
    push_word(16'hA5A5, '0);
    push_word(16'h5A5A, '0);
    cmd(4);
    uc = int'(underrun);
    for (int i = 0; i < 3; i++) begin
      step("under");
      uc += int'(underrun);
      if (i >= 1) begin
        chk("under.hold", 32'(dq), 32'h5A5A);
        chk("under.dqm",  32'(dqm), 32'h3);
      end
    end
    step("under");
    chk("under.count", 32'(uc), 32'd2);

    // Back-to-back bursts: 2 then 3 with no gap
    for (int i = 0; i < 5; i++) push_word(DW'(16'h0200 + i), '0);
    drv = 0;
    cmd(2);              drv += int'(dq !== DQ_Z);
    step("b2b");         drv += int'(dq !== DQ_Z);
    cmd(3);              drv += int'(dq !== DQ_Z);
    step("b2b");         drv += int'(dq !== DQ_Z);
    step("b2b");         drv += int'(dq !== DQ_Z);
    chk("b2b.driven", 32'(drv), 32'd5);
    step("b2b");
    chk("b2b.z", 32'(dq), 32'(DQ_Z));

    // Command while busy is rejected
    for (int i = 0; i < 4; i++) push_word(DW'(16'h0300 + i), '0);
    cmd(4);
    cmd(2);
    chk("err.pulse", 32'(cmd_err), 32'h1);
    chk("err.busy",  32'(busy), 32'h1);
    step("err");
    chk("err.clear", 32'(cmd_err), 32'h0);
    repeat (3) step("err");

    // Abort after beat 1 of 8
    for (int i = 0; i < 8; i++) push_word(DW'(16'h0400 + i), '0);
    cmd(8);
    step("abort");
    wr_if.wr_abort = 1;
    step("abort");
    chk("abort.z",     32'(dq), 32'(DQ_Z));
    chk("abort.level", 32'(level), 32'd6);

    // Reset asserted mid-burst releases DQ immediately
    cmd(4);
    step("rstmid");
    rst_n = 0;
    #1;
    chk("rstmid.dq",    32'(dq), 32'(DQ_Z));
    chk("rstmid.dqm",   32'(dqm), 32'h3);
    chk("rstmid.level", 32'(level), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("rsthold");
    @(negedge clk);
    rst_n = 1;

`ifdef SDRAM_WR_MASK_EN
    push_word(16'h1234, 2'b00);
    push_word(16'h5678, 2'b10);
    cmd(2);
    chk("mask.beat0", 32'(dqm), 32'h0);
    step("mask");
    chk("mask.beat1", 32'(dqm), 32'h2);
    step("mask");
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      wr_if.in_valid  = ($urandom_range(0, 2) != 0);
      wr_if.in_data   = DW'($urandom_range(0, (1 << DW) - 2));
`ifdef SDRAM_WR_MASK_EN
      wr_if.in_mask   = MW'($urandom);
`endif
      wr_if.wr_cmd    = ($urandom_range(0, 5) == 0);
      wr_if.burst_len = BL_W'($urandom);
      wr_if.wr_abort  = ($urandom_range(0, 40) == 0);
      step("rnd");
    end
    repeat (20) step("tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_wr_datapath.md
# sdram_wr_datapath

Parametrised SDRAM write-data path. It replaces the fixed single-flag DQ driver with a buffered one. Upstream write data is queued in a FIFO through a valid/ready handshake. Each write burst issued by the SDRAM command controller is then played out on the bidirectional DQ bus, with a registered output enable and per-byte DQM. The block sits between the frame/line writer and the SDRAM pins, alongside the command state machine.

## Interface
- DW, 16, DQ width in bits; multiple of 8.
- DEPTH, 16, FIFO depth in words; power of 2, at least 2.
- BL_W, 4, width of `burst_len`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_cmd`  in  1  high in the cycle the SDRAM WRITE command is on the command bus.
- `burst_len`  in  BL_W  beats for this burst, sampled with `wr_cmd`; 0 is treated as 1.
- `wr_abort`  in  1  burst stop / precharge: terminate the current burst.
- `in_data`  in  DW  upstream write word.
- `in_mask`  in  DW/8  per-byte mask, 1 = do not write. Present only with the macro.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept a word; combinational, equal to !full.
- `sdram_data`  inout  DW  DQ pins.
- `sdram_dqm`  out  DW/8  DQM pins.
- `busy`  out  1  burst in progress and not in its final beat.
- `underrun`  out  1  one-cycle pulse when a beat was due and the FIFO was empty.
- `cmd_err`  out  1  one-cycle pulse when `wr_cmd` is ignored.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO**
  - A push happens on an edge where `in_valid` and `in_ready` are both high.
  - A pop happens only when a beat is loaded and the FIFO is not empty.
  - Occupancy updates as count + push − pop. There is no bypass: a word pushed into an empty FIFO can be popped on the next edge at the earliest.
  - Pointers wrap modulo DEPTH.
- **Beat counter `beats_left`** (0 = idle)
  - A `wr_cmd` is accepted when `beats_left` ≤ 1 and `wr_abort` is low.
  - On acceptance: load `beats_left` = max(`burst_len`, 1), load beat 0 into the output register, set OE to 1.
  - On an edge with `beats_left` > 1: decrement and load the next beat.
  - On an edge with `beats_left` == 1 and no accepted `wr_cmd`: go to 0 and set OE to 0.
  - Gapless bursts: a `wr_cmd` in the final-beat cycle continues directly into the new burst.
- **Beat load**
  - If the FIFO is not empty: pop into the output data and DQM registers. DQM comes from the stored mask with the macro, and is 0 without it.
  - If the FIFO is empty: keep the previous data, set DQM to all ones, pulse `underrun`, and still consume the beat.
- **Command errors**
  - `wr_cmd` while `busy` is high (`beats_left` > 1) is ignored and pulses `cmd_err`.
  - `wr_cmd` on the same edge as `wr_abort` is ignored and pulses `cmd_err`.
- **Abort**
  - `wr_abort` sets `beats_left` to 0 and OE to 0 at the next edge, and nothing is popped.
  - Words for the unplayed beats stay in the FIFO.
- **Pin drive**
  - `sdram_data` = OE ? data register : all Z.
  - `sdram_dqm` = OE ? DQM register : all ones.
- `busy` = (`beats_left` > 1).

## Timing
- Reset values:
  - OE 0, so `sdram_data` is Z.
  - `sdram_dqm` all ones.
  - `busy`, `underrun`, `cmd_err` all 0.
  - FIFO empty: `fifo_level` 0, `in_ready` 1.
  - `beats_left` 0.
  - Reset asserted mid-burst releases DQ within the reset assertion (asynchronous).
- A `wr_cmd` sampled at edge N drives beat k during cycle N+1+k, for k = 0..L−1. This is one cycle of registered latency, matching the controller's data phase.
- OE drops at edge N+L, so DQ is Z in cycle N+L+1 unless a back-to-back burst was accepted.
- `underrun` and `cmd_err` are high for exactly the cycle after the offending edge.
- `fifo_level` is registered; `in_ready` follows it combinationally.

## Configuration
- Macro `SDRAM_WR_MASK_EN`.
- Defined:
  - `in_mask` port exists.
  - The FIFO stores DW + DW/8 bits per word.
  - Driven DQM equals the stored mask.
- Undefined:
  - No `in_mask` port; the FIFO stores DW bits.
  - Driven DQM is 0 except on underrun beats, which are all ones.
  - All other behaviour is identical.

## Test plan
- Push 0x1111..0x4444, then `wr_cmd` with `burst_len`=4 at edge N → DQ = 0x1111, 0x2222, 0x3333, 0x4444 in cycles N+1..N+4; Z in N+5; `fifo_level` 0; DQM 0.
- Reset then idle → DQ Z, DQM 0x3 (DW=16), `in_ready` 1; push 16 words → `in_ready` 0; push attempt ignored, level stays 16.
- Two words queued, `burst_len`=4 → beats 2–3 keep the last data with DQM 0x3; `underrun` pulses twice.
- `wr_cmd` in the final beat of a 2-beat burst → a 3-beat burst follows with no Z gap (5 contiguous driven cycles); `wr_cmd` mid-burst → ignored, `cmd_err` for 1 cycle.
- `wr_abort` after beat 1 of 8 → DQ Z next cycle; `fifo_level` drops by 2 only; `rst_n` low mid-burst → DQ Z immediately.
- With `SDRAM_WR_MASK_EN`, mask 0x2 on word 2 → DQM 0x2 on beat 1 only.
